// File: rtl/int_alu_scheduler_pkg.sv
// Shared types and bus constants for the integer ALU scheduler.
package int_alu_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_OP,
    S_RD_RES,
    S_RESP
  } state_e;

  localparam logic [3:0]  IntAlu      = 4'h3;
  localparam logic [11:0] ALU_Source1 = 12'h001;
  localparam logic [11:0] ALU_Source2 = 12'h002;
  localparam logic [11:0] AluStatusIn = 12'h003;
  localparam logic [11:0] ALU_Result  = 12'h004;

  localparam logic [7:0] Iadd  = 8'h01;
  localparam logic [7:0] Isub  = 8'h02;
  localparam logic [7:0] Imult = 8'h03;
  localparam logic [7:0] Idiv  = 8'h04;

endpackage

// File: rtl/int_alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins.
module int_alu_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    idx
);

  int  j;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/int_alu_scheduler.sv
// Shares the integer ALU between NUM_REQ requesters by running its
// register protocol (Source1, Source2, StatusIn, Result) on DataBus.
module int_alu_scheduler
  import int_alu_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OPW     = 8
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_op,
  input  logic [NUM_REQ*16-1:0]  req_a,
  input  logic [NUM_REQ*16-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic [15:0]            address,
  output logic                   nRead,
  output logic                   nWrite,
  inout  wire  [255:0]           DataBus
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d, win_q, win_d;
  logic [OPW-1:0]      op_q, op_d;
  logic [15:0]         a_q, a_d, b_q, b_d;
  logic                err_q, err_d;
  logic [15:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic                nread_q, nread_d, nwrite_q, nwrite_d, drive_q, drive_d;
  logic                bus_req_q, bus_req_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                arb_en;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDXW-1:0]     arb_idx;
  logic [OPW-1:0]      op_sel;
  logic [15:0]         a_sel, b_sel;
  logic                op_known;
  logic                unused_bus;

  // Only accept once the bus has actually been requested, so nothing is taken during reset.
  assign arb_en = (state_q == S_IDLE) && bus_gnt && bus_req_q;

  int_alu_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign op_sel   = req_op[arb_idx*OPW +: OPW];
  assign a_sel    = req_a[arb_idx*16 +: 16];
  assign b_sel    = req_b[arb_idx*16 +: 16];
  assign op_known = (op_sel == OPW'(Iadd)) || (op_sel == OPW'(Isub)) ||
                    (op_sel == OPW'(Imult)) || (op_sel == OPW'(Idiv));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_en && (|req_valid)) begin
          req_ready = arb_grant;
          win_d     = arb_idx;
          op_d      = op_sel;
          a_d       = a_sel;
          b_d       = b_sel;
          err_d     = !op_known || ((op_sel == OPW'(Idiv)) && (b_sel == 16'h0000));
          ptr_d     = (arb_idx == IDXW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d   = S_WR_A;
        end
      end
      S_WR_A:  if (bus_gnt) state_d = S_WR_B;
      S_WR_B:  if (bus_gnt) state_d = S_WR_OP;
      S_WR_OP: if (bus_gnt) state_d = S_RD_RES;
      S_RD_RES: begin
        if (bus_gnt) begin
          rsp_data_d         = DataBus[15:0];
          rsp_err_d          = err_q;
          rsp_valid_d[win_q] = 1'b1;
          state_d            = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes are registered as a decode of the state being entered.
  always_comb begin
    addr_d    = '0;
    nread_d   = 1'b1;
    nwrite_d  = 1'b1;
    drive_d   = 1'b0;
    wdata_d   = '0;
    bus_req_d = |req_valid;
    case (state_d)
      S_WR_A: begin
        addr_d = {IntAlu, ALU_Source1}; nwrite_d = 1'b0; drive_d = 1'b1; wdata_d = a_d; bus_req_d = 1'b1;
      end
      S_WR_B: begin
        addr_d = {IntAlu, ALU_Source2}; nwrite_d = 1'b0; drive_d = 1'b1; wdata_d = b_d; bus_req_d = 1'b1;
      end
      S_WR_OP: begin
        addr_d = {IntAlu, AluStatusIn}; nwrite_d = 1'b0; drive_d = 1'b1; wdata_d = 16'(op_d); bus_req_d = 1'b1;
      end
      S_RD_RES: begin
        addr_d = {IntAlu, ALU_Result}; nread_d = 1'b0; bus_req_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      nread_q     <= 1'b1;
      nwrite_q    <= 1'b1;
      drive_q     <= 1'b0;
      wdata_q     <= '0;
      bus_req_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      nread_q     <= nread_d;
      nwrite_q    <= nwrite_d;
      drive_q     <= drive_d;
      wdata_q     <= wdata_d;
      bus_req_q   <= bus_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Losing the grant releases the bus immediately; the held state replays when it returns.
  assign address   = bus_gnt ? addr_q : '0;
  assign nRead     = nread_q | ~bus_gnt;
  assign nWrite    = nwrite_q | ~bus_gnt;
  assign DataBus   = (drive_q && bus_gnt) ? {240'b0, wdata_q} : {256{1'bz}};
  assign bus_req   = bus_req_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign unused_bus = ^DataBus[255:16];

endmodule
